// File: rtl/asic2_pkg.sv
// asic2_pkg: shared types, round constant and SHA-256 round helper functions.
package asic2_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {WAIT, LOAD, GAP, ROUND, OUT, DONE} state_t;

    localparam word_t K0 = 32'h428a2f98;

    function automatic word_t ror(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: combinational single SHA-256 round over working variables A..H.
module sha256_round
    import asic2_pkg::*;
(
    input  word_t v [8],
    input  word_t w,
    input  word_t k,
    output word_t nv [8]
);

    word_t t1, t2;

    assign t1 = v[7] + big_sigma1(v[4]) + ch(v[4], v[5], v[6]) + k + w;
    assign t2 = big_sigma0(v[0]) + maj(v[0], v[1], v[2]);

    assign nv[0] = t1 + t2;
    assign nv[1] = v[0];
    assign nv[2] = v[1];
    assign nv[3] = v[2];
    assign nv[4] = v[3] + t1;
    assign nv[5] = v[4];
    assign nv[6] = v[5];
    assign nv[7] = v[6];

endmodule

// File: rtl/asic2_sha256_core.sv
// asic2_sha256_core: fixed-schedule serial load, one SHA-256 round, serial unload.
// ASIC2_AUTO_RESTART_EN: return to WAIT after the last output word instead of holding in DONE.
module asic2_sha256_core
    import asic2_pkg::*;
#(
    parameter word_t ROUND_K     = K0,
    parameter int    LEAD_CYCLES = 2,
    parameter int    GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    output logic [31:0] out_var
);

    localparam logic [4:0] LOAD_AT  = 5'(LEAD_CYCLES);
    localparam logic [4:0] GAP_AT   = 5'(LEAD_CYCLES + 8);
    localparam logic [4:0] ROUND_AT = 5'(LEAD_CYCLES + 8 + GAP_CYCLES);
    localparam logic [4:0] OUT_AT   = 5'(LEAD_CYCLES + 9 + GAP_CYCLES);
    localparam logic [4:0] LAST     = 5'(LEAD_CYCLES + 16 + GAP_CYCLES);

    state_t      state;
    logic [4:0]  cnt;
    word_t       v  [8];
    word_t       nv [8];
    word_t       w;

    function automatic state_t phase_state(input logic [4:0] p);
        return p < LOAD_AT  ? WAIT  :
               p < GAP_AT   ? LOAD  :
               p < ROUND_AT ? GAP   :
               p == ROUND_AT ? ROUND :
               p <= LAST    ? OUT   : DONE;
    endfunction

    // W is consumed on the same edge it is captured, so the round sees the bus directly
    sha256_round u_round (
        .v  (v),
        .w  (state == ROUND ? in_data : w),
        .k  (ROUND_K),
        .nv (nv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT;
            cnt     <= '0;
            w       <= '0;
            out_var <= '0;
            for (int i = 0; i < 8; i++) v[i] <= '0;
        end else begin
            case (state)
                LOAD:    v[3'(cnt - LOAD_AT)] <= in_data;
                ROUND: begin
                    w <= in_data;
                    for (int i = 0; i < 8; i++) v[i] <= nv[i];
                end
                OUT:     out_var <= v[3'(cnt - OUT_AT)];
                default: ;
            endcase
            if (state == OUT && cnt == LAST) begin
`ifdef ASIC2_AUTO_RESTART_EN
                cnt   <= '0;
                state <= WAIT;
`else
                cnt   <= LAST + 5'd1;
                state <= DONE;
`endif
            end else if (state != DONE) begin
                cnt   <= cnt + 5'd1;
                state <= phase_state(cnt + 5'd1);
            end
        end
    end

endmodule

// File: tb/tb_asic2_sha256_core.sv
// tb_asic2_sha256_core: directed vectors with hand-computed round results.
module tb_asic2_sha256_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic [31:0] out_var;

    int checks = 0;
    int failures = 0;

    typedef logic [0:7][31:0] words_t;

    localparam words_t IV      = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam words_t EXP_NOM = {32'hfe08884d, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                  32'h9ac7e2a2, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
    localparam words_t EXP_ABC = {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                  32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
    localparam words_t ONES    = {8{32'hffffffff}};
    // T1 = 4*ffffffff + K = 428a2f94, T2 = fffffffe
    localparam words_t EXP_ONE = {32'h428a2f92, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                                  32'h428a2f93, 32'hffffffff, 32'hffffffff, 32'hffffffff};

    asic2_sha256_core dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .out_var (out_var)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [31:0] d);
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(32'h0);
        tick(32'h0);
        check("reset_out", out_var, 32'h0);
        reset = 1'b0;
    endtask

    task automatic run_seq(input words_t v, input logic [31:0] w, input words_t exp,
                           input logic [31:0] junk);
        for (int i = 0; i < 2; i++) begin
            tick(junk);
            check("wait_out", out_var, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            tick(v[i]);
            check("load_out", out_var, 32'h0);
        end
        tick(junk);
        check("gap_out", out_var, 32'h0);
        tick(w);
        check("round_out", out_var, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(junk);
            check($sformatf("out_word%0d", i), out_var, exp[i]);
        end
    endtask

    initial begin
        do_reset();
        run_seq(IV, 32'h02000000, EXP_NOM, 32'h0);
`ifdef ASIC2_AUTO_RESTART_EN
        run_seq(IV, 32'h02000000, EXP_NOM, 32'hdeadbeef);
`else
        for (int i = 0; i < 5; i++) begin
            tick($urandom);
            check("done_hold", out_var, 32'h1f83d9ab);
        end
`endif
        do_reset();
        run_seq(IV, 32'h61626380, EXP_ABC, 32'hdeadbeef);

        do_reset();
        tick(32'h0);
        tick(32'h0);
        for (int i = 0; i < 3; i++) tick(IV[i]);
        reset = 1'b1;
        tick(IV[3]);
        check("mid_reset", out_var, 32'h0);
        reset = 1'b0;
        run_seq(IV, 32'h02000000, EXP_NOM, 32'h12345678);

        do_reset();
        run_seq(ONES, 32'hffffffff, EXP_ONE, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
